muldiv: RTL

Iterative RV64M multiply/divide unit in the execute stage, directly upstream of the memory stage. It accepts one M-extension operation from execute, stalls the pipeline via `busy_o`, and presents a 64-bit result in the cycle execute forwards it as `aluout` to memory. It covers the MUL/MULH/MULHSU/MULHU, DIV/DIVU/REM/REMU and W variants.

---
 rtl/muldiv_pkg.sv | 46 ++++
 rtl/muldiv.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative RV64M multiply/divide unit:
//   - funct3 encodings of the M-extension operations
//   - controller state encoding (IDLE / RUN / DONE)
//   - 32->64 bit sign/zero extension helpers used by the W variants
//   - operand signedness decode per operation
// -----------------------------------------------------------------------------
package muldiv_pkg;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } funct3_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic [63:0] zext32(input logic [31:0] v);
        return {32'd0, v};
    endfunction

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM
    function automatic logic op_signed_a(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM
    function automatic logic op_signed_b(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv.sv
// -----------------------------------------------------------------------------
// muldiv
// Iterative RV64M multiply/divide unit sitting in the execute stage. One
// M-extension operation is accepted in IDLE, the pipeline is stalled through
// busy_o while the shared 128-bit shift register iterates one bit per cycle,
// and the result is presented on result_o with a one-cycle done_o pulse.
//
// Ports:
//   clock     in   1     rising-edge clock
//   reset     in   1     synchronous active-low reset
//   start_i   in   1     M-op present in execute (sampled only in IDLE)
//   flush_i   in   1     abort in-flight op, back to IDLE without done_o
//   funct3_i  in   3     M-op selector (MUL..REMU)
//   word_i    in   1     W variant (ignored for MULH/MULHSU/MULHU)
//   src1_i    in   XLEN  rs1 value, latched at start
//   src2_i    in   XLEN  rs2 value, latched at start
//   busy_o    out  1     stall request (combinational)
//   done_o    out  1     one-cycle pulse, result_o valid
//   result_o  out  XLEN  result, held until replaced by the next op
//
// Build option: MULDIV_FAST_MUL_EN -- multiplies use a single-cycle
// combinational product registered at start; divides stay iterative.
// -----------------------------------------------------------------------------
module muldiv
    import muldiv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [2:0]      funct3_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    state_t              state_r;
    state_t              state_next_s;
    logic                done_r;
    logic [6:0]          cnt_r;
    logic [2*XLEN-1:0]   acc_r;
    logic [XLEN-1:0]     opb_r;
    funct3_t             f3_r;
    logic                word_r;
    logic                neg_res_r;
    logic                neg_rem_r;
    logic [XLEN-1:0]     result_r;

    logic                accept_s;
    logic                signed_a_s;
    logic                signed_b_s;
    logic                is_div_s;
    logic                word_eff_s;
    logic [XLEN-1:0]     a_ext_s;
    logic [XLEN-1:0]     b_ext_s;
    logic                s1_s;
    logic                s2_s;
    logic [XLEN-1:0]     mag_a_s;
    logic [XLEN-1:0]     mag_b_s;
    logic [XLEN-1:0]     min_s;
    logic                div_zero_s;
    logic                div_ovf_s;
    logic [XLEN-1:0]     spec_q_s;
    logic [XLEN-1:0]     spec_r_s;
    logic [XLEN-1:0]     spec_sel_s;
    logic [XLEN-1:0]     special_res_s;
    logic                imm_s;
    logic [XLEN-1:0]     imm_res_s;

    logic [XLEN:0]       mul_sum_s;
    logic [2*XLEN-1:0]   mul_step_s;
    logic [XLEN:0]       rem_sh_s;
    logic [XLEN:0]       diff_s;
    logic [2*XLEN-1:0]   div_step_s;
    logic [2*XLEN-1:0]   step_s;
    logic [2*XLEN-1:0]   prod_s;
    logic [2*XLEN-1:0]   prod_fix_s;
    logic [XLEN-1:0]     quot_fix_s;
    logic [XLEN-1:0]     rem_fix_s;
    logic [XLEN-1:0]     sel_s;
    logic [XLEN-1:0]     final_res_s;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0]   fast_a_s;
    logic [2*XLEN-1:0]   fast_b_s;
    logic [2*XLEN-1:0]   fast_prod_s;
    logic [XLEN-1:0]     fast_sel_s;
`endif

    assign accept_s = (state_r == ST_IDLE) && start_i && !flush_i;

    // Operand preparation at start: W extension, magnitudes, signs, special cases
    always_comb begin
        signed_a_s = op_signed_a(funct3_i);
        signed_b_s = op_signed_b(funct3_i);
        is_div_s   = funct3_i[2];
        word_eff_s = word_i && (is_div_s || (funct3_i == F3_MUL));
        if (word_eff_s) begin
            a_ext_s = signed_a_s ? sext32(src1_i[31:0]) : zext32(src1_i[31:0]);
            b_ext_s = signed_b_s ? sext32(src2_i[31:0]) : zext32(src2_i[31:0]);
        end else begin
            a_ext_s = src1_i;
            b_ext_s = src2_i;
        end
        s1_s    = signed_a_s && a_ext_s[XLEN-1];
        s2_s    = signed_b_s && b_ext_s[XLEN-1];
        mag_a_s = s1_s ? (64'd0 - a_ext_s) : a_ext_s;
        mag_b_s = s2_s ? (64'd0 - b_ext_s) : b_ext_s;
        // most-negative value as seen after W sign extension
        min_s   = word_eff_s ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        div_zero_s = is_div_s && (b_ext_s == 64'd0);
        div_ovf_s  = is_div_s && signed_a_s && (a_ext_s == min_s) &&
                     (b_ext_s == 64'hFFFF_FFFF_FFFF_FFFF);
        if (div_zero_s) begin
            spec_q_s = 64'hFFFF_FFFF_FFFF_FFFF;
            spec_r_s = a_ext_s;
        end else begin
            spec_q_s = a_ext_s;
            spec_r_s = 64'd0;
        end
        // funct3[1] distinguishes REM/REMU from DIV/DIVU
        spec_sel_s    = funct3_i[1] ? spec_r_s : spec_q_s;
        special_res_s = word_eff_s ? sext32(spec_sel_s[31:0]) : spec_sel_s;
    end

`ifdef MULDIV_FAST_MUL_EN
    // Single-cycle product: low 128 bits of an extended multiply are exact for
    // any mix of signed/unsigned operands
    always_comb begin
        fast_a_s    = signed_a_s ? {{XLEN{a_ext_s[XLEN-1]}}, a_ext_s} : {64'd0, a_ext_s};
        fast_b_s    = signed_b_s ? {{XLEN{b_ext_s[XLEN-1]}}, b_ext_s} : {64'd0, b_ext_s};
        fast_prod_s = fast_a_s * fast_b_s;
        fast_sel_s  = (funct3_i == F3_MUL) ? fast_prod_s[XLEN-1:0] : fast_prod_s[2*XLEN-1:XLEN];
        imm_s       = div_zero_s || div_ovf_s || !is_div_s;
        if (is_div_s) begin
            imm_res_s = special_res_s;
        end else begin
            imm_res_s = word_eff_s ? sext32(fast_sel_s[31:0]) : fast_sel_s;
        end
    end
`else
    // Only the divide special cases bypass the iterative path
    always_comb begin
        imm_s     = div_zero_s || div_ovf_s;
        imm_res_s = special_res_s;
    end
`endif

    // One iteration of shift-add multiply or restoring divide on acc_r
    always_comb begin
        // multiply: add multiplicand into the high half when the LSB is set, shift right
        mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opb_r} : 65'd0);
        mul_step_s = {mul_sum_s, acc_r[XLEN-1:1]};
        // divide: shift left, trial-subtract the divisor, keep it if non-negative
        rem_sh_s   = acc_r[2*XLEN-1:XLEN-1];
        diff_s     = rem_sh_s - {1'b0, opb_r};
        if (diff_s[XLEN]) begin
            div_step_s = {rem_sh_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
        end else begin
            div_step_s = {diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
        end
        step_s = f3_r[2] ? div_step_s : mul_step_s;
    end

    // Sign fix and result selection applied to the value of the final iteration
    always_comb begin
        // a W multiply runs 32 steps, leaving its 64-bit product at bits [95:32]
        prod_s     = word_r ? {64'd0, step_s[95:32]} : step_s;
        prod_fix_s = neg_res_r ? (128'd0 - prod_s) : prod_s;
        quot_fix_s = neg_res_r ? (64'd0 - step_s[XLEN-1:0]) : step_s[XLEN-1:0];
        rem_fix_s  = neg_rem_r ? (64'd0 - step_s[2*XLEN-1:XLEN]) : step_s[2*XLEN-1:XLEN];
        case (f3_r)
            F3_MUL:                        sel_s = prod_fix_s[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  sel_s = prod_fix_s[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               sel_s = quot_fix_s;
            F3_REM, F3_REMU:               sel_s = rem_fix_s;
            default:                       sel_s = 64'd0;
        endcase
        final_res_s = word_r ? sext32(sel_s[31:0]) : sel_s;
    end

    // Next-state logic and the combinational stall request
    always_comb begin
        state_next_s = state_r;
        busy_o       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    busy_o       = 1'b1;
                    state_next_s = imm_s ? ST_DONE : ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                busy_o = 1'b1;
                if (cnt_r == 7'd1) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                // the same instruction is still in execute, so start is ignored
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
        if (flush_i) begin
            state_next_s = ST_IDLE;
        end else begin
            state_next_s = state_next_s;
        end
    end

    // State register and registered done pulse
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            done_r  <= (state_next_s == ST_DONE);
        end
    end

    // Datapath: operand latch at start, iteration in RUN, result register
    always_ff @(posedge clock) begin
        if (!reset) begin
            acc_r     <= 128'd0;
            opb_r     <= 64'd0;
            cnt_r     <= 7'd0;
            f3_r      <= F3_MUL;
            word_r    <= 1'b0;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            result_r  <= 64'd0;
        end else if (flush_i) begin
            cnt_r <= 7'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_i) begin
                        f3_r      <= funct3_t'(funct3_i);
                        word_r    <= word_eff_s;
                        neg_res_r <= s1_s ^ s2_s;
                        neg_rem_r <= s1_s;
                        opb_r     <= mag_b_s;
                        // a W divide needs its 32-bit dividend at the top of the low half
                        if (is_div_s && word_eff_s) begin
                            acc_r <= {64'd0, mag_a_s[31:0], 32'd0};
                        end else begin
                            acc_r <= {64'd0, mag_a_s};
                        end
                        if (imm_s) begin
                            result_r <= imm_res_s;
                            cnt_r    <= 7'd0;
                        end else begin
                            cnt_r <= word_eff_s ? 7'd32 : 7'd64;
                        end
                    end
                end
                ST_RUN: begin
                    acc_r <= step_s;
                    cnt_r <= cnt_r - 7'd1;
                    if (cnt_r == 7'd1) begin
                        result_r <= final_res_s;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign done_o   = done_r;
    assign result_o = result_r;

endmodule
